// File: rtl/eei_pkg.sv
// Shared types and constants for the EEI issue unit.
package eei_pkg;

   // Width of a register index (32 architectural registers).
   localparam int REG_IDX_W = 5;

   // Issue sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATHER = 3'd1,
      ST_REQ    = 3'd2,
      ST_WB     = 3'd3,
      ST_DONE   = 3'd4
   } eei_state_e;

   // Result writeback kinds returned by the EEI target.
   typedef enum logic [1:0] {
      RD_OP_NONE      = 2'd0,
      RD_OP_SINGLE    = 2'd1,
      RD_OP_BATCH     = 2'd2,
      RD_OP_BATCH_EXT = 2'd3
   } rd_op_e;

endpackage

// File: rtl/eei_issue.sv
// EEI issue unit: accepts an instruction, gathers its operands from the
// register file, issues one request to the EEI target, writes the returned
// results back and reports completion.
//
// Handshakes: ins_valid/ins_ready is a strict valid/ready pair -- a transfer
// happens on a rising edge where both are high, and ins_ready is high only
// while idle. On the EEI side eei_req rises in REQ and, together with every
// eei_* output, stays stable until the edge that samples eei_ack high (an
// ack in the first REQ cycle is legal); eei_req drops on the following cycle.
module eei_issue
   import eei_pkg::*;
#(
   parameter int RS_MAX  = 8,
   parameter int RD_MAX  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   // instruction side
   input  logic                        ins_valid,
   output logic                        ins_ready,
   input  logic                        ins_ext,
   input  logic [2:0]                  ins_funct3,
   input  logic [6:0]                  ins_funct7,
   input  logic [REG_IDX_W-1:0]        ins_rs1,
   input  logic [REG_IDX_W-1:0]        ins_rs2,
   input  logic [REG_IDX_W-1:0]        ins_rd,
   input  logic [REG_IDX_W-1:0]        ins_batch_start,
   input  logic [REG_IDX_W-1:0]        ins_batch_len,
   // register file
   output logic [REG_IDX_W-1:0]        rf_raddr,
   input  logic [31:0]                 rf_rdata,
   output logic                        rf_we,
   output logic [REG_IDX_W-1:0]        rf_waddr,
   output logic [31:0]                 rf_wdata,
   // EEI initiator
   output logic                        eei_req,
   output logic                        eei_ext,
   output logic [2:0]                  eei_funct3,
   output logic [6:0]                  eei_funct7,
   output logic [REG_IDX_W-1:0]        eei_batch_start,
   output logic [REG_IDX_W-1:0]        eei_batch_len,
   output logic [RS_MAX-1:0][31:0]     eei_rs_val,
   input  logic                        eei_ack,
   input  logic                        eei_error,
   input  logic [1:0]                  eei_rd_op,
   input  logic [REG_IDX_W-1:0]        eei_rd_len,
   input  logic [RD_MAX-1:0][31:0]     eei_rd_val,
   // completion
   output logic                        done_valid,
   output logic                        done_error,
   output logic                        busy,
   // debug view of the sequencer state
   output eei_state_e                  state
);

   localparam int RS_IW = (RS_MAX > 1) ? $clog2(RS_MAX) : 1;
   localparam int RD_IW = (RD_MAX > 1) ? $clog2(RD_MAX) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [REG_IDX_W:0] RS_MAX_W  = (REG_IDX_W + 1)'(RS_MAX);
   localparam logic [REG_IDX_W:0] RD_MAX_W  = (REG_IDX_W + 1)'(RD_MAX);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);

   eei_state_e                 state_q, state_d;

   // latched instruction
   logic                       ext_q;
   logic [2:0]                 funct3_q;
   logic [6:0]                 funct7_q;
   logic [REG_IDX_W-1:0]       rs1_q, rs2_q, rd_q, bstart_q, blen_q;

   // operand buffer, shared slot/register counter, REQ wait counter
   logic [RS_MAX-1:0][31:0]    rs_buf_q;
   logic [REG_IDX_W-1:0]       idx_q;
   logic [TO_W-1:0]            tcnt_q;

   // response captured on the ack cycle
   rd_op_e                     rd_op_q;
   logic [REG_IDX_W-1:0]       rd_len_q;
   logic                       err_q;
   logic [RD_MAX-1:0][31:0]    rd_val_q;

   // sticky completion error for the current instruction
   logic                       fail_q;

   // combinational helpers
   logic                       oversize;
   logic [REG_IDX_W-1:0]       n_ops;
   logic [REG_IDX_W-1:0]       gather_addr;
   logic [REG_IDX_W-1:0]       batch_addr;
   logic                       rd_len_bad;
   logic                       gather_last;
   logic                       fail_set;

   assign oversize    = ins_ext && ({1'b0, ins_batch_len} > RS_MAX_W);
   assign n_ops       = ext_q ? blen_q : REG_IDX_W'(2);
   assign batch_addr  = bstart_q + idx_q;  // wraps mod 32 naturally
   assign gather_addr = ext_q ? batch_addr : ((idx_q == '0) ? rs1_q : rs2_q);
   assign rd_len_bad  = {1'b0, rd_len_q} > RD_MAX_W;

   assign busy            = (state_q != ST_IDLE);
   assign state           = state_q;
   assign eei_ext         = ext_q;
   assign eei_funct3      = funct3_q;
   assign eei_funct7      = funct7_q;
   assign eei_batch_start = bstart_q;
   assign eei_batch_len   = blen_q;
   assign eei_rs_val      = rs_buf_q;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and all handshake / register-file / completion outputs.
   always_comb begin
      state_d     = state_q;
      ins_ready   = 1'b0;
      eei_req     = 1'b0;
      rf_raddr    = '0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      done_valid  = 1'b0;
      done_error  = 1'b0;
      gather_last = 1'b0;
      fail_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ins_ready = 1'b1;
            if (ins_valid) begin
               if (oversize)                               state_d = ST_DONE;
               else if (ins_ext && (ins_batch_len == '0))  state_d = ST_REQ;
               else                                        state_d = ST_GATHER;
            end
         end
         ST_GATHER: begin
            rf_raddr = gather_addr;
            if (idx_q == n_ops - REG_IDX_W'(1)) begin
               gather_last = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            eei_req = 1'b1;
            if (eei_ack) begin
               state_d = ST_WB;
            end else if (tcnt_q == TO_LAST) begin
               fail_set = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_WB: begin
            if (err_q) begin
               fail_set = 1'b1;
               state_d  = ST_DONE;
            end else begin
               case (rd_op_q)
                  RD_OP_SINGLE: begin
                     rf_waddr = rd_q;
                     rf_wdata = rd_val_q[0];
                     rf_we    = (rd_q != '0);
                     state_d  = ST_DONE;
                  end
                  RD_OP_BATCH, RD_OP_BATCH_EXT: begin
                     if (rd_len_bad) begin
                        fail_set = 1'b1;
                        state_d  = ST_DONE;
                     end else if (rd_len_q == '0) begin
                        state_d = ST_DONE;
                     end else begin
                        rf_waddr = batch_addr;
                        rf_wdata = rd_val_q[idx_q[RD_IW-1:0]];
                        rf_we    = (batch_addr != '0);
                        if (idx_q == rd_len_q - REG_IDX_W'(1)) state_d = ST_DONE;
                     end
                  end
                  default: state_d = ST_DONE;  // RD_OP_NONE
               endcase
            end
         end
         ST_DONE: begin
            done_valid = 1'b1;
            done_error = fail_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Instruction latch, operand gather, response capture and counters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ext_q    <= 1'b0;
         funct3_q <= '0;
         funct7_q <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         bstart_q <= '0;
         blen_q   <= '0;
         rs_buf_q <= '0;
         idx_q    <= '0;
         tcnt_q   <= '0;
         rd_op_q  <= RD_OP_NONE;
         rd_len_q <= '0;
         err_q    <= 1'b0;
         rd_val_q <= '0;
         fail_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ins_valid) begin
                  ext_q    <= ins_ext;
                  funct3_q <= ins_funct3;
                  funct7_q <= ins_funct7;
                  rs1_q    <= ins_rs1;
                  rs2_q    <= ins_rs2;
                  rd_q     <= ins_rd;
                  bstart_q <= ins_batch_start;
                  blen_q   <= ins_batch_len;
                  rs_buf_q <= '0;
                  idx_q    <= '0;
                  tcnt_q   <= '0;
                  fail_q   <= oversize;
               end
            end
            ST_GATHER: begin
               rs_buf_q[idx_q[RS_IW-1:0]] <= rf_rdata;
               idx_q <= gather_last ? '0 : idx_q + REG_IDX_W'(1);
            end
            ST_REQ: begin
               if (eei_ack) begin
                  rd_op_q  <= rd_op_e'(eei_rd_op);
                  rd_len_q <= eei_rd_len;
                  err_q    <= eei_error;
                  rd_val_q <= eei_rd_val;
                  idx_q    <= '0;
               end else begin
                  tcnt_q <= tcnt_q + TO_W'(1);
               end
               if (fail_set) fail_q <= 1'b1;
            end
            ST_WB: begin
               idx_q <= idx_q + REG_IDX_W'(1);
               if (fail_set) fail_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/eei_issue.md
EEI_ISSUE -- requirements
Module: eei_issue

Interface
REQ-001 SHALL have parameter RS_MAX, default 8, number of operand slots in eei_rs_val.
REQ-002 SHALL have parameter RD_MAX, default 8, number of result slots in eei_rd_val.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for eei_ack.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_i in 1 (rising edge), rst_i in 1.
REQ-005 SHALL have the instruction-side ports:
- ins_valid in 1, ins_ready out 1: issue handshake.
- ins_ext in 1: enhanced (batch) instruction.
- ins_funct3 in 3, ins_funct7 in 7: opcode fields.
- ins_rs1, ins_rs2, ins_rd in 5 each: register indices.
- ins_batch_start in 5, ins_batch_len in 5: batch window.
REQ-006 SHALL have the register-file ports:
- rf_raddr out 5, rf_rdata in 32: combinational read, data valid in the same cycle.
- rf_we out 1, rf_waddr out 5, rf_wdata out 32: write port.
REQ-007 SHALL have the EEI initiator ports:
- eei_req out 1, eei_ext out 1, eei_funct3 out 3, eei_funct7 out 7.
- eei_batch_start out 5, eei_batch_len out 5.
- eei_rs_val out RS_MAX x 32.
- eei_ack in 1, eei_error in 1.
- eei_rd_op in 2, eei_rd_len in 5.
- eei_rd_val in RD_MAX x 32.
REQ-008 SHALL have the completion ports: done_valid out 1 (one-cycle pulse), done_error out 1 (qualified by done_valid), busy out 1.

Function
REQ-009 SHALL implement the states IDLE, GATHER, REQ, WB and DONE, with busy=1 in every state except IDLE and ins_ready=1 only in IDLE.
REQ-010 SHALL, on ins_valid&ins_ready in IDLE, latch all ins_* fields, clear the operand buffer and the index counter, and go to GATHER.
REQ-011 SHALL determine the operand count N in GATHER as 2 (rs1 then rs2) when ins_ext=0, and as ins_batch_len when ins_ext=1.
REQ-012 SHALL read register (batch_start+i) mod 32 into slot i during GATHER in ext mode, one register per cycle.
REQ-013 SHALL, when ins_ext=1 and ins_batch_len>RS_MAX, skip GATHER and REQ entirely, never assert eei_req, and go directly to DONE with done_error=1.
REQ-014 SHALL, when ins_ext=1 and ins_batch_len=0, take zero GATHER cycles and go directly to REQ.
REQ-015 SHALL assert eei_req in REQ and hold it and all eei_* outputs stable until eei_ack is sampled high; an ack in the first REQ cycle is legal.
REQ-016 SHALL capture eei_rd_op, eei_rd_len, eei_error and eei_rd_val on the ack cycle, deassert eei_req on the next cycle and go to WB.
REQ-017 SHALL, when no ack arrives within TIMEOUT REQ cycles, drop eei_req and go to DONE with done_error=1, with no writeback.
REQ-018 SHALL perform no writeback and go to DONE with done_error=1 when the captured eei_error=1.
REQ-019 SHALL handle the captured eei_rd_op in WB as follows:
- 0: no write, 1 cycle.
- 1: write rd_val[0] to ins_rd, 1 cycle.
- 2 or 3: write rd_val[i] to (batch_start+i) mod 32 for i=0..rd_len-1, one per cycle.
- rd_len=0: one idle cycle.
REQ-020 SHALL, when rd_op is 2 or 3 and rd_len>RD_MAX, perform no write and set done_error=1.
REQ-021 SHALL suppress rf_we for waddr=0 while still consuming that cycle.
REQ-022 SHALL pulse done_valid for exactly one cycle in DONE and then return to IDLE.
REQ-023 SHALL complete a non-ext instruction with a same-cycle ack in 5 cycles from acceptance to done_valid (GATHER 2, REQ 1, WB 1, DONE 1).

Reset
REQ-024 SHALL, on rst_i asserted (asynchronous, at any time including mid-operation), enter IDLE with eei_req=0, rf_we=0, done_valid=0, done_error=0, busy=0, all counters 0 and operand buffer 0; the in-flight instruction is discarded.
REQ-025 SHALL have ins_ready=1 in the first cycle after rst_i deasserts.

Structure
REQ-026 SHALL place the state enum, the rd_op encodings (NONE=0, SINGLE=1, BATCH=2, BATCH_EXT=3) and the register-index width constant in the shared package eei_pkg.
REQ-027 SHALL be one module with no sub-modules; the timeout counter is inline.

Verification
REQ-028 The bench SHALL cover: ext=0, x5=0x11, x6=0x22, rs1=5, rs2=6, rd=7, responder acks same cycle with rd_op=1, rd_val[0]=0x33 -> rs_val[0..1]=0x11,0x22, x7<=0x33, done_valid at cycle 5, done_error=0.
REQ-029 The bench SHALL cover: ext=1, batch_start=30, batch_len=4 -> reads x30,x31,x0,x1 into slots 0..3; rd_op=3, rd_len=4 -> writes x30,x31,x1 (x0 suppressed).
REQ-030 The bench SHALL cover: ext=1, batch_len=9 with RS_MAX=8 -> eei_req never asserted, done_error=1.
REQ-031 The bench SHALL cover: responder never acks -> eei_req drops after 255 REQ cycles, done_error=1, no rf_we.
REQ-032 The bench SHALL cover: ack with eei_error=1, rd_op=1 -> no rf_we, done_error=1.
REQ-033 The bench SHALL cover: rst_i asserted mid-WB of a 4-register batch -> rf_we=0 immediately, IDLE, ins_ready=1 after release.
